reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter LAT_W, default 6: width of the per-register latency counter.
REQ-002 Parameter CP0_LAT, default 2: cycles after MTC0 issue before MFC0 may issue.
REQ-003 clk  input  1: single clock; all state on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 id_valid  input  1: ID holds a valid instruction.
REQ-006 id_read_en_1 / id_read_en_2  input  1 each: GPR source operand used.
REQ-007 id_read_addr_1 / id_read_addr_2  input  5 each: GPR source addresses.
REQ-008 id_write_en  input  1: instruction writes a GPR.
REQ-009 id_write_addr  input  5: GPR destination.
REQ-010 id_write_lat  input  LAT_W: cycles until result is forwardable (ALU 0, load 1, MULT/DIV larger).
REQ-011 id_cp_read_en / id_cp_write_en  input  1 each: MFC0 / MTC0 in ID.
REQ-012 flush  input  1: pipeline flush (exception/ERET) from CP0.
REQ-013 stall  output  1: hold IF/ID and bubble EX this cycle.
REQ-014 issue  output  1: ID instruction advances at this edge.
REQ-015 stall_cnt  output  32: saturating count of stalled cycles.

Function
REQ-016 One LAT_W counter per GPR 1..31 (busy = counter != 0); GPR 0 has no counter and is never busy.
REQ-017 One CP0 counter, width clog2(CP0_LAT+1).
REQ-018 stall combinational, same cycle: id_valid & !flush & (raw | waw | cp).
REQ-019 raw = (id_read_en_1 & busy[id_read_addr_1]) | (id_read_en_2 & busy[id_read_addr_2]).
REQ-020 waw = id_write_en & busy[id_write_addr].
REQ-021 cp = id_cp_read_en & (cp0 counter != 0).
REQ-022 issue = id_valid & !stall & !flush.
REQ-023 Each edge, every nonzero counter decrements by 1.
REQ-024 On issue with id_write_en, id_write_addr != 0, id_write_lat != 0: that counter loads id_write_lat, overriding its decrement.
REQ-025 On issue with id_write_lat == 0, or write to GPR 0, no counter changes.
REQ-026 On issue with id_cp_write_en, CP0 counter loads CP0_LAT.
REQ-027 Source equal to own destination is checked against the pre-issue counter only.
REQ-028 Counter value 1 stalls this cycle; the next cycle it is 0 and the instruction issues; load-use costs exactly 1 stall cycle.
REQ-029 flush at an edge clears all counters, suppresses issue; flush dominates every other event.
REQ-030 stall_cnt increments on each edge with stall = 1; holds at 0xFFFFFFFF.
REQ-031 No state changes when id_valid = 0 except counter decrement and flush.

Reset
REQ-032 rst asserted: all GPR counters, CP0 counter and stall_cnt go to 0 immediately, not waiting for clk.
REQ-033 Outputs during reset: stall = 0; issue = 0.
REQ-034 Reset mid-stall abandons the stall; the first edge after deassertion sees all registers ready.

Structure
REQ-035 REG_ADDR_BUS, LAT_W and CP0_LAT defaults belong in the shared bus/opcode include.
REQ-036 One sub-module, sb_entry: a loadable down-counter with busy output, instantiated 31 times plus once for CP0 with narrower width.
REQ-037 The per-operand busy lookup is a plain 32:1 mux; no other hierarchy.

Verification
REQ-038 Load-use: LW $2 (lat 1) issues; next cycle ADDU $3,$2,$4 -> stall = 1 for 1 cycle, issue on the 2nd cycle, stall_cnt = 1.
REQ-039 ALU forward: ADDU $5 (lat 0), then SUBU reading $5 -> no stall; both issue on consecutive cycles.
REQ-040 Long op: DIV result to $8, lat 32, then read $8 -> stall 32 cycles, issue on the 33rd; a read of $9 during the wait is not the one stalled.
REQ-041 CP0: MTC0 Status then MFC0 Status back-to-back -> 2 stall cycles.
REQ-042 flush: lat 20 write to $7, flush after 3 cycles -> all counters 0; the next read of $7 issues the same cycle.
REQ-043 Reset: assert rst asynchronously with $4 counter = 5 -> stall drops before the next edge; stall_cnt = 0; reads of $0 never stall.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared widths and defaults for the register scoreboard: GPR address bus, latency counter
// width and the MTC0-to-MFC0 spacing.
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned NUM_GPR     = 32;
  localparam int unsigned LAT_W_DEF   = 6;
  localparam int unsigned CP0_LAT_DEF = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle. The master is the decode stage and CP0 flush source;
// the slave is the scoreboard.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = LAT_W_DEF
) ();

  logic             id_valid;
  logic             id_read_en_1;
  logic             id_read_en_2;
  reg_addr_t        id_read_addr_1;
  reg_addr_t        id_read_addr_2;
  logic             id_write_en;
  reg_addr_t        id_write_addr;
  logic [LAT_W-1:0] id_write_lat;
  logic             id_cp_read_en;
  logic             id_cp_write_en;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [31:0]      stall_cnt;

  modport master (
    output id_valid, id_read_en_1, id_read_en_2, id_read_addr_1, id_read_addr_2,
           id_write_en, id_write_addr, id_write_lat, id_cp_read_en, id_cp_write_en, flush,
    input  stall, issue, stall_cnt
  );

  modport slave (
    input  id_valid, id_read_en_1, id_read_en_2, id_read_addr_1, id_read_addr_2,
           id_write_en, id_write_addr, id_write_lat, id_cp_read_en, id_cp_write_en, flush,
    output stall, issue, stall_cnt
  );

endinterface

// File: rtl/sb_entry.sv
// One scoreboard entry: a loadable down-counter that is busy while nonzero.
// Clear beats load, and load beats the free-running decrement.
module sb_entry #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - W'(1);
    if (load_i)      cnt_d = load_val_i;
    if (clr_i)       cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// GPR/CP0 hazard scoreboard: stalls the ID instruction on RAW, WAW or an MFC0 following
// a recent MTC0; tracks result latency per GPR and counts stalled cycles.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W   = LAT_W_DEF,
  parameter int unsigned CP0_LAT = CP0_LAT_DEF
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave bus
);

  localparam int unsigned CpW = cnt_width(CP0_LAT);

  logic [NUM_GPR-1:0] busy;
  logic               cp_busy;
  logic               raw, waw, cp;
  logic               stall, issue;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  // GPR 0 is hardwired zero, so it never carries a pending result.
  assign busy[0] = 1'b0;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_gpr
    logic load;
    assign load = issue & bus.id_write_en & (bus.id_write_addr == reg_addr_t'(g)) &
                  (bus.id_write_lat != '0);
    sb_entry #(.W(LAT_W)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (bus.flush),
      .load_i     (load),
      .load_val_i (bus.id_write_lat),
      .busy_o     (busy[g])
    );
  end

  sb_entry #(.W(CpW)) u_cp0_entry (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (bus.flush),
    .load_i     (issue & bus.id_cp_write_en),
    .load_val_i (CpW'(CP0_LAT)),
    .busy_o     (cp_busy)
  );

  // Hazards are judged on pre-issue counters, so a source equal to its own destination
  // only sees the older producer.
  assign raw = (bus.id_read_en_1 & busy[bus.id_read_addr_1]) |
               (bus.id_read_en_2 & busy[bus.id_read_addr_2]);
  assign waw = bus.id_write_en & busy[bus.id_write_addr];
  assign cp  = bus.id_cp_read_en & cp_busy;

  assign stall = ~rst & bus.id_valid & ~bus.flush & (raw | waw | cp);
  assign issue = ~rst & bus.id_valid & ~stall & ~bus.flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall     = stall;
  assign bus.issue     = issue;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a ready-time reference model predicts stall/issue/
// stall_cnt for every cycle; a negedge monitor pops and compares.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int unsigned LAT_W   = 6;
  localparam int unsigned CP0_LAT = 2;

  typedef struct {
    bit       valid;
    bit       re1;
    bit [4:0] ra1;
    bit       re2;
    bit [4:0] ra2;
    bit       we;
    bit [4:0] wa;
    int       lat;
    bit       cpr;
    bit       cpw;
    bit       flush;
  } stim_t;

  typedef struct {
    bit     stall;
    bit     issue;
    longint scnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.LAT_W(LAT_W)) bus ();

  reg_scoreboard #(.LAT_W(LAT_W), .CP0_LAT(CP0_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks   = 0;
  int     failures = 0;
  exp_t   exp_q[$];
  // Model: first cycle index at which each register's result is forwardable.
  int     ready[32];
  int     cp_ready;
  longint scnt;
  int     cyc;
  bit     obs_stall, obs_issue;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    cp_ready = 0;
    scnt     = 0;
  endtask

  function automatic bit busy_m(input bit [4:0] r);
    return (r != 0) && (ready[r] > cyc);
  endfunction

  task automatic calc(input stim_t s, output bit st, output bit is);
    bit hz;
    hz = (s.re1 && busy_m(s.ra1)) || (s.re2 && busy_m(s.ra2)) || (s.we && busy_m(s.wa)) ||
         (s.cpr && (cp_ready > cyc));
    st = !rst && s.valid && !s.flush && hz;
    is = !rst && s.valid && !s.flush && !hz;
  endtask

  task automatic edge_update(input stim_t s);
    bit st, is;
    calc(s, st, is);
    if (rst) begin
      model_reset();
    end else if (s.flush) begin
      for (int r = 0; r < 32; r++) ready[r] = 0;
      cp_ready = 0;
    end else begin
      if (is && s.we && (s.wa != 0) && (s.lat != 0)) ready[s.wa] = cyc + 1 + s.lat;
      if (is && s.cpw) cp_ready = cyc + 1 + int'(CP0_LAT);
      if (st && (scnt < 64'hFFFF_FFFF)) scnt++;
    end
    cyc++;
  endtask

  task automatic drive(input stim_t s);
    bus.id_valid       = s.valid;
    bus.id_read_en_1   = s.re1;
    bus.id_read_addr_1 = s.ra1;
    bus.id_read_en_2   = s.re2;
    bus.id_read_addr_2 = s.ra2;
    bus.id_write_en    = s.we;
    bus.id_write_addr  = s.wa;
    bus.id_write_lat   = LAT_W'(s.lat);
    bus.id_cp_read_en  = s.cpr;
    bus.id_cp_write_en = s.cpw;
    bus.flush          = s.flush;
  endtask

  task automatic push_exp(input stim_t s);
    bit   st, is;
    exp_t e;
    calc(s, st, is);
    e.stall = st;
    e.issue = is;
    e.scnt  = scnt;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(input stim_t s);
    drive(s);
    push_exp(s);
    @(negedge clk);
    obs_stall = bus.stall;
    obs_issue = bus.issue;
    @(posedge clk);
    edge_update(s);
    #1;
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t ins(input bit re1, input bit [4:0] ra1, input bit re2,
                                input bit [4:0] ra2, input bit we, input bit [4:0] wa,
                                input int lat);
    stim_t s;
    s = nop();
    s.valid = 1'b1;
    s.re1 = re1; s.ra1 = ra1; s.re2 = re2; s.ra2 = ra2;
    s.we = we; s.wa = wa; s.lat = lat;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.valid = ($urandom_range(0, 9) != 0);
    s.re1   = 1'($urandom_range(0, 1));
    s.ra1   = 5'($urandom_range(0, 7));
    s.re2   = 1'($urandom_range(0, 1));
    s.ra2   = 5'($urandom_range(0, 7));
    s.we    = 1'($urandom_range(0, 1));
    s.wa    = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       s.lat = 0;
      1:       s.lat = 1;
      2:       s.lat = int'($urandom_range(2, 5));
      default: s.lat = int'($urandom_range(6, 63));
    endcase
    s.cpr   = ($urandom_range(0, 7) == 0);
    s.cpw   = ($urandom_range(0, 7) == 0);
    s.flush = ($urandom_range(0, 19) == 0);
    return s;
  endfunction

  task automatic run_until_issue(input stim_t s, output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      apply(s);
      if (obs_stall) n++;
      if (obs_issue) break;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_stall", longint'(bus.stall), longint'(e.stall));
      chk("sb_issue", longint'(bus.issue), longint'(e.issue));
      chk("sb_stall_cnt", longint'(bus.stall_cnt), e.scnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    n;
    rst = 1'b1;
    cyc = 0;
    model_reset();
    drive(nop());
    #1;
    chk("reset_stall", longint'(bus.stall), 0);
    chk("reset_issue", longint'(bus.issue), 0);
    chk("reset_stall_cnt", longint'(bus.stall_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use: one stall cycle.
    apply(ins(0, 0, 0, 0, 1, 2, 1));
    run_until_issue(ins(1, 2, 1, 4, 1, 3, 0), n);
    chk("loaduse_stalls", n, 1);
    chk("loaduse_stall_cnt", longint'(bus.stall_cnt), 1);

    // ALU result forwardable immediately.
    apply(ins(0, 0, 0, 0, 1, 5, 0));
    chk("alu_first_issue", longint'(obs_issue), 1);
    apply(ins(1, 5, 0, 0, 1, 6, 0));
    chk("alu_dep_stall", longint'(obs_stall), 0);
    chk("alu_dep_issue", longint'(obs_issue), 1);

    // Long divide.
    apply(ins(0, 0, 0, 0, 1, 8, 32));
    run_until_issue(ins(1, 8, 0, 0, 0, 0, 0), n);
    chk("div_stalls", n, 32);
    apply(ins(0, 0, 0, 0, 1, 8, 32));
    apply(ins(1, 9, 0, 0, 1, 10, 0));
    chk("div_other_reg_issue", longint'(obs_issue), 1);

    // MTC0 then MFC0.
    s = nop();
    s.valid = 1'b1;
    s.cpw   = 1'b1;
    apply(s);
    s.cpw = 1'b0;
    s.cpr = 1'b1;
    run_until_issue(s, n);
    chk("cp0_stalls", n, 2);

    // Flush clears pending results.
    apply(ins(0, 0, 0, 0, 1, 7, 20));
    repeat (3) apply(nop());
    s = nop();
    s.flush = 1'b1;
    apply(s);
    apply(ins(1, 7, 0, 0, 0, 0, 0));
    chk("flush_read_stall", longint'(obs_stall), 0);
    chk("flush_read_issue", longint'(obs_issue), 1);

    // GPR 0 never busy.
    apply(ins(0, 0, 0, 0, 1, 0, 5));
    apply(ins(1, 0, 1, 0, 1, 0, 3));
    chk("r0_stall", longint'(obs_stall), 0);

    // Asynchronous reset mid-stall.
    apply(ins(0, 0, 0, 0, 1, 4, 5));
    s = ins(1, 4, 0, 0, 0, 0, 0);
    drive(s);
    push_exp(s);
    @(negedge clk);
    chk("async_pre_stall", longint'(bus.stall), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_stall", longint'(bus.stall), 0);
    chk("async_rst_issue", longint'(bus.issue), 0);
    chk("async_rst_stall_cnt", longint'(bus.stall_cnt), 0);
    @(posedge clk);
    edge_update(s);
    #1;
    apply(nop());
    rst = 1'b0;
    apply(s);
    chk("post_rst_stall", longint'(obs_stall), 0);
    chk("post_rst_issue", longint'(obs_issue), 1);

    repeat (500) apply(rnd());
    repeat (2) apply(nop());
    @(negedge clk);
    #1;
    chk("queue_drained", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
